// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch,
// dmem-wait and halt handling, with saturating perf counters and a dmem watchdog.
//
// state | meaning
// RUN   | normal issue; hazards resolved by stalls/flushes
// HALT  | HALT retired; pipeline frozen until reset
// ERROR | dmem watchdog expired; pipeline frozen until reset
module pipeline_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             IFID_uses_rt,
  input  logic [4:0]       IDEX_rt,
  input  logic             IDEX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             EXMEM_MemAccess,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             EXMEM_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             MEMWB_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       mem_wait, load_use;

  assign mem_wait = EXMEM_MemAccess && !dmem_ready;
  assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                    ((IDEX_rt == IFID_rs) || (IFID_uses_rt && (IDEX_rt == IFID_rt)));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = 8'd0;
    PC_write     = 1'b0;
    IFID_write   = 1'b0;
    IDEX_write   = 1'b0;
    EXMEM_write  = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    MEMWB_flush  = 1'b0;
    if (!reset_n) begin
      // bubbles fill the pipe while reset is held
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      MEMWB_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            MEMWB_flush  = 1'b1;
            wait_cnt_nxt = wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) state_nxt = ERROR;
          end else begin
            if (halt_req) state_nxt = HALT;
            if (EX_branch_taken) begin
              PC_write    = 1'b1;
              IFID_write  = 1'b1;
              IDEX_write  = 1'b1;
              EXMEM_write = 1'b1;
              IFID_flush  = 1'b1;
              IDEX_flush  = 1'b1;
            end else if (load_use) begin
              IDEX_write  = 1'b1;
              EXMEM_write = 1'b1;
              IDEX_flush  = 1'b1;
            end else begin
              PC_write    = 1'b1;
              IFID_write  = 1'b1;
              IDEX_write  = 1'b1;
              EXMEM_write = 1'b1;
            end
          end
        end
        HALT:    ;
        ERROR:   ;
        default: state_nxt = ERROR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == RUN) begin
        if (!PC_write && (stall_count != CNT_MAX))
          stall_count <= stall_count + CNT_W'(1);
        if (IFID_flush && (flush_count != CNT_MAX))
          flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  assign halted  = (state == HALT);
  assign mem_err = (state == ERROR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a rule-level reference model.
module tb_pipeline_ctrl;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CNT_SAT  = 15;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] IFID_rs, IFID_rt, IDEX_rt;
  logic IFID_uses_rt, IDEX_MemRead, EX_branch_taken, EXMEM_MemAccess, dmem_ready, halt_req;
  logic PC_write, IFID_write, IDEX_write, EXMEM_write;
  logic IFID_flush, IDEX_flush, MEMWB_flush, halted, mem_err;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_uses_rt(IFID_uses_rt),
    .IDEX_rt(IDEX_rt), .IDEX_MemRead(IDEX_MemRead), .EX_branch_taken(EX_branch_taken),
    .EXMEM_MemAccess(EXMEM_MemAccess), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
    .EXMEM_write(EXMEM_write), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .MEMWB_flush(MEMWB_flush), .halted(halted), .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: 0 = running, 1 = halted, 2 = watchdog error
  int m_mode  = 0;
  int m_waits = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] xrt, input logic mr, input logic br,
                      input logic ma, input logic rdy, input logic hr, input logic rn,
                      input string tag);
    logic [6:0] exp_ctrl, got_ctrl;
    logic [9:0] exp_reg, got_reg;
    bit mw, lu;
    IFID_rs = rs; IFID_rt = rt; IFID_uses_rt = urt; IDEX_rt = xrt; IDEX_MemRead = mr;
    EX_branch_taken = br; EXMEM_MemAccess = ma; dmem_ready = rdy; halt_req = hr; reset_n = rn;
    #1;
    mw = ma && !rdy;
    lu = mr && (xrt != 0) && (xrt == rs || (urt && xrt == rt));
    // {PC, IFID, IDEX, EXMEM writes, IFID, IDEX, MEMWB flushes}
    if (!rn)              exp_ctrl = 7'b0000_111;
    else if (m_mode != 0) exp_ctrl = 7'b0000_000;
    else if (mw)          exp_ctrl = 7'b0000_001;
    else if (br)          exp_ctrl = 7'b1111_110;
    else if (lu)          exp_ctrl = 7'b0011_010;
    else                  exp_ctrl = 7'b1111_000;
    got_ctrl = {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush, MEMWB_flush};
    n_checks++;
    assert (got_ctrl === exp_ctrl)
      else begin
        n_errors++;
        $error("FAIL %s ctrl: got %b expected %b", tag, got_ctrl, exp_ctrl);
      end
    @(posedge clk);
    if (!rn) begin
      m_mode = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    end else if (m_mode == 0) begin
      if (!exp_ctrl[6] && m_stall < CNT_SAT) m_stall++;
      if (exp_ctrl[2] && m_flush < CNT_SAT) m_flush++;
      if (mw) begin
        m_waits++;
        if (m_waits >= MAX_WAIT) m_mode = 2;
      end else begin
        m_waits = 0;
        if (hr) m_mode = 1;
      end
    end
    #1;
    exp_reg = {m_mode == 1, m_mode == 2, 4'(m_stall), 4'(m_flush)};
    got_reg = {halted, mem_err, stall_count, flush_count};
    n_checks++;
    assert (got_reg === exp_reg)
      else begin
        n_errors++;
        $error("FAIL %s regs {halted,mem_err,stall,flush}: got %b expected %b", tag, got_reg, exp_reg);
      end
  endtask

  task automatic idle(input string tag);
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, tag);
  endtask

  task automatic do_reset(input string tag);
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [4:0] r_rs, r_rt, r_xrt;
    logic r_urt, r_mr, r_br, r_ma, r_rdy, r_hr, r_rn;
    #1;
    do_reset("reset0");
    do_reset("reset1");
    idle("idle");

    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "lu_rs");
    idle("lu_release");
    step(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "lu_r0");
    step(5'd4, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "lu_rt");
    step(5'd4, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "lu_rt_unused");

    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "br_over_lu");

    for (int i = 0; i < 3; i++)
      step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "memwait_all");
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "mem_ready");

    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "halt_in_wait");
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "halt_take");
    step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "halted_frozen");
    idle("halted_idle");
    do_reset("halt_reset");
    idle("post_halt");

    for (int i = 0; i < MAX_WAIT + 2; i++)
      step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "watchdog");
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "err_frozen");
    do_reset("err_reset");
    idle("post_err");

    for (int i = 0; i < MAX_WAIT - 1; i++)
      step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "wd_edge");
    idle("wd_edge_clear");
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "wd_restart");

    do_reset("sat_reset");
    for (int i = 0; i < 20; i++)
      step(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "sat_stall");
    for (int i = 0; i < 18; i++)
      step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "sat_flush");
    do_reset("sat_clear");
    idle("sat_after");

    for (int i = 0; i < 400; i++) begin
      r_rs  = 5'($urandom_range(0, 3));
      r_rt  = 5'($urandom_range(0, 3));
      r_xrt = 5'($urandom_range(0, 3));
      r_urt = 1'($urandom_range(0, 1));
      r_mr  = 1'($urandom_range(0, 1));
      r_br  = ($urandom_range(0, 3) == 0);
      r_ma  = 1'($urandom_range(0, 1));
      r_rdy = ($urandom_range(0, 2) != 0);
      r_hr  = ($urandom_range(0, 29) == 0);
      r_rn  = ($urandom_range(0, 59) != 0);
      if (m_mode != 0 && $urandom_range(0, 3) == 0) r_rn = 1'b0;
      step(r_rs, r_rt, r_urt, r_xrt, r_mr, r_br, r_ma, r_rdy, r_hr, r_rn, "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipelined CPU. It sits beside the forwarding unit. It resolves the hazards forwarding cannot cover:
- load-use dependencies
- taken branches resolved in EX
- data-memory wait states
- halt

It does this by driving the per-stage write-enable and bubble controls. It also keeps saturating performance counters and a watchdog on data-memory waits.

## Interface
Parameters:
- CNT_W, 16, width of stall_count and flush_count
- MAX_WAIT, 8, consecutive dmem wait cycles tolerated before declaring mem_err (legal range 1..255)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- IFID_rs  input  5  rs field of instruction in ID
- IFID_rt  input  5  rt field of instruction in ID
- IFID_uses_rt  input  1  ID instruction reads rt as a source
- IDEX_rt  input  5  destination rt of instruction in EX
- IDEX_MemRead  input  1  EX instruction is a load
- EX_branch_taken  input  1  taken branch/jump resolved in EX this cycle
- EXMEM_MemAccess  input  1  MEM-stage instruction is a load or store
- dmem_ready  input  1  data memory completes access this cycle
- halt_req  input  1  HALT instruction is in WB
- PC_write  output  1  PC register load enable
- IFID_write  output  1  IF/ID register load enable
- IDEX_write  output  1  ID/EX register load enable
- EXMEM_write  output  1  EX/MEM register load enable
- IFID_flush  output  1  load NOP into IF/ID
- IDEX_flush  output  1  load NOP into ID/EX (control bits zeroed)
- MEMWB_flush  output  1  load NOP into MEM/WB
- halted  output  1  CPU halted (sticky)
- mem_err  output  1  dmem watchdog expired (sticky)
- stall_count  output  CNT_W  stall cycles, saturating
- flush_count  output  CNT_W  branch flush events, saturating

## Operation
States (registered): RUN, HALT, ERROR. Reset state is RUN.

Each cycle, derive these combinational conditions:
- mem_wait = EXMEM_MemAccess && !dmem_ready
- load_use = IDEX_MemRead && IDEX_rt != 0 && (IDEX_rt == IFID_rs || (IFID_uses_rt && IDEX_rt == IFID_rt))

RUN, highest priority first:
- **mem_wait:** freeze PC, IFID, IDEX and EXMEM (all writes 0). Set MEMWB_flush=1. Other flushes 0. Branch and load_use are ignored this cycle; they re-present because EX is frozen.
- **EX_branch_taken:** all writes 1. Set IFID_flush=1 and IDEX_flush=1. The branch squashes any load-use stall on the ID instruction.
- **load_use:** PC_write=0 and IFID_write=0. IDEX_write=1 with IDEX_flush=1. EXMEM_write=1.
- **Otherwise:** all writes 1, all flushes 0.

Watchdog:
- wait_cnt (8-bit) increments on each mem_wait cycle in RUN and clears on any non-mem_wait cycle.
- If mem_wait holds with wait_cnt == MAX_WAIT-1, the next edge goes to ERROR.

State transitions:
- halt_req in RUN while not mem_wait → HALT at the next edge.
- mem_wait has priority over halt_req.

HALT and ERROR:
- All writes 0, all flushes 0.
- halted=1 in HALT; mem_err=1 in ERROR.
- Both are exit-only-by-reset.

Counters:
- stall_count increments on each RUN cycle with PC_write=0.
- flush_count increments on each RUN cycle with IFID_flush=1.
- Both saturate at 2^CNT_W-1 with no wrap, and freeze in HALT/ERROR.

## Timing
- Write enables and flushes are combinational from the registered state and the current inputs, with zero-cycle latency. This is required so a stall blocks the same edge.
- A load-use stall lasts exactly 1 cycle if there is no mem_wait: the next cycle the load is in MEM and load_use drops.
- The branch penalty is 2 bubbles: the IF/ID and ID/EX flush occur on the same edge.
- halted, mem_err and the counters are registered, updating 1 edge after the causing cycle.
- While reset_n=0 at an edge: state←RUN; wait_cnt, stall_count and flush_count ←0; halted and mem_err ←0.
- While reset_n=0 (combinationally): all writes 0 and all flushes 1, so bubbles fill the pipe.
- Reset mid-wait or mid-stall takes effect at that edge. The first post-reset cycle is RUN with no residual stall.
- Simultaneous mem_wait + EX_branch_taken + load_use: only the mem_wait response is produced. flush_count does not increment until the branch actually flushes.

## Test plan
- **Load-use:** IDEX_MemRead=1, IDEX_rt=5, IFID_rs=5 for 1 cycle → PC_write=0, IFID_write=0, IDEX_flush=1; stall_count 0→1. With IDEX_rt=0 instead → no stall.
- **Branch vs load-use:** EX_branch_taken=1 with load_use true → IFID_flush=1, IDEX_flush=1, PC_write=1; flush_count +1, stall_count unchanged.
- **Memory wait:** EXMEM_MemAccess=1, dmem_ready low for 3 cycles, then high → 3 cycles with all writes 0 and MEMWB_flush=1; stall_count +3; normal operation on the 4th cycle.
- **Watchdog:** MAX_WAIT=8, dmem_ready held low → on edge 8 state=ERROR and mem_err=1; all writes stay 0 until reset_n=0 for 1 edge, then RUN with mem_err=0.
- **Halt:** halt_req=1 in RUN with no wait → halted=1 next edge and all writes 0. halt_req during mem_wait → ignored until the wait clears.
- **Saturation:** CNT_W=4, force 20 load-use stalls → stall_count stops at 15. Reset asserted → counters read 0 the next cycle.
